// File: rtl/cordiccart2pol_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordiccart2pol_pkg
// Purpose  : Shared widths, helper function and request record for the
//            cordiccart2pol shared-multiplier block.
// Contents : A_W / B_W / P_W operand and product widths, FULL_W full signed
//            product width, clog2(), mul_req_t operand+tag record.
// Revision : 1.0  initial release
// ============================================================================
package cordiccart2pol_pkg;

    localparam int A_W      = 6;           // operand A, unsigned
    localparam int B_W      = 8;           // operand B, signed
    localparam int P_W      = 13;          // delivered product width
    localparam int FULL_W   = A_W + B_W;   // full signed product of {0,a} x b
    localparam int ID_MAX_W = 3;           // tag field wide enough for 8 requesters

    // Ceiling log2 for v >= 2 (requester counts 2..8).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return r;
    endfunction

    typedef struct packed {
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
        logic [ID_MAX_W-1:0] id;
    } mul_req_t;

endpackage : cordiccart2pol_pkg
`default_nettype wire

// File: rtl/cordiccart2pol_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : cordiccart2pol_rr_pick
// Purpose  : Combinational rotate-priority picker. Scans req_i upward from
//            index ptr_i, wrapping at NUM_REQ-1, and grants the first set bit.
// Ports    : req_i   [NUM_REQ]  request vector
//            ptr_i   [ID_W]     starting index of the scan
//            grant_o [NUM_REQ]  one-hot grant (all zero if no request)
//            idx_o   [ID_W]     encoded index of the grant
//            any_o              high when some request is granted
// Revision : 1.0  initial release
// ============================================================================
module cordiccart2pol_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = ID_W'(j);
            end
        end
    end

endmodule : cordiccart2pol_rr_pick
`default_nettype wire

// File: rtl/cordiccart2pol_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordiccart2pol_mul_arbiter
// Purpose  : Shares one 6u x 8s -> 13-bit multiplier among NUM_REQ requesters
//            with round-robin arbitration and a two-stage stallable pipeline
//            (operand register S1, product register S2).
// Ports    : ap_clk, ap_rst           clock, synchronous active-high reset
//            req_valid/req_ready      per-requester handshake
//            req_a/req_b              packed operands, slice i*W +: W
//            rsp_valid/rsp_ready      result handshake
//            rsp_p/rsp_id             product (low P_W bits) and issuer tag
//            busy                     either pipeline stage occupied
//            stall_cnt                saturating back-pressure cycle count
// Revision : 1.0  initial release
// ============================================================================
module cordiccart2pol_mul_arbiter
    import cordiccart2pol_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [P_W-1:0]         rsp_p,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic               s1_v_q;
    mul_req_t           s1_q;
    logic               s2_v_q;
    logic [P_W-1:0]     rsp_p_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [CNT_W-1:0]   stall_q;

    logic               w_adv2;
    logic               w_adv1;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_xfer;
    logic [FULL_W-1:0]  w_a_ext;
    logic [FULL_W-1:0]  w_b_ext;
    logic [FULL_W-1:0]  w_prod;
    logic               w_unused;

    // S2 can take new data when empty or draining; S1 when empty or moving on.
    assign w_adv2 = !s2_v_q || rsp_ready;
    assign w_adv1 = !s1_v_q || w_adv2;

    cordiccart2pol_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    // Reset masks the handshake outputs so nothing is accepted or offered
    // while the pipeline is being cleared.
    assign req_ready = (w_adv1 && !ap_rst) ? w_grant : '0;
    assign w_xfer    = w_any && w_adv1 && !ap_rst;

    assign ptr_d = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);

    // A is zero-extended (unsigned), B sign-extended; the 14-bit product is
    // exact, then truncated to P_W bits on the way into S2.
    assign w_a_ext = {{(FULL_W-A_W){1'b0}}, s1_q.a};
    assign w_b_ext = {{(FULL_W-B_W){s1_q.b[B_W-1]}}, s1_q.b};
    assign w_prod  = $signed(w_a_ext) * $signed(w_b_ext);

    assign w_unused = ^{s1_q.id, w_prod[FULL_W-1:P_W]};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_v_q   <= 1'b0;
            s1_q     <= '0;
            s2_v_q   <= 1'b0;
            rsp_p_q  <= '0;
            rsp_id_q <= '0;
            ptr_q    <= '0;
            stall_q  <= '0;
        end else begin
            if (w_adv2) begin
                s2_v_q   <= s1_v_q;
                rsp_p_q  <= w_prod[P_W-1:0];
                rsp_id_q <= s1_q.id[ID_W-1:0];
            end
            if (w_adv1) begin
                s1_v_q <= w_xfer;
                s1_q.a <= req_a[w_idx*A_W +: A_W];
                s1_q.b <= req_b[w_idx*B_W +: B_W];
                s1_q.id <= ID_MAX_W'(w_idx);
            end
            if (w_xfer) begin
                ptr_q <= ptr_d;
            end
            if (s2_v_q && !rsp_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = s2_v_q && !ap_rst;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_v_q || s2_v_q;
    assign stall_cnt = stall_q;

endmodule : cordiccart2pol_mul_arbiter
`default_nettype wire

// File: tb/tb_cordiccart2pol_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordiccart2pol_mul_arbiter
// Purpose  : Self-checking bench for cordiccart2pol_mul_arbiter. A queue model
//            of in-flight results predicts grants, results and counters.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordiccart2pol_mul_arbiter;

    localparam int N = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*6-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [12:0]   rsp_p;
    logic [1:0]    rsp_id;
    logic          busy;
    logic [15:0]   stall_cnt;

    logic [5:0]    a_arr [N];
    logic [7:0]    b_arr [N];

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*6 +: 6] = a_arr[i];
            req_b[i*8 +: 8] = b_arr[i];
        end
    end

    cordiccart2pol_mul_arbiter #(
        .NUM_REQ (N),
        .ID_W    (2),
        .CNT_W   (16)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: ordered results in flight; q_out marks the one sitting
    // in the output register.
    int q_p  [$];
    int q_id [$];
    bit q_out[$];
    int mptr   = 0;
    int mstall = 0;
    int exp_g;
    logic [N-1:0] exp_rdy;
    bit   exp_v;
    bit   last_xfer;
    int   last_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called 1 time unit after a rising edge; samples on the falling edge.
    task automatic sample_check();
        bit full;
        #4;
        exp_g = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (exp_g < 0 && req_valid[j]) exp_g = j;
        end
        full    = (q_p.size() == 2) && !rsp_ready;
        exp_rdy = (ap_rst || exp_g < 0 || full) ? '0 : N'(1 << exp_g);
        exp_v   = !ap_rst && (q_p.size() > 0) && q_out[0];
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (!ap_rst) begin
            check_eq("busy", 32'(busy), 32'(q_p.size() > 0));
            check_eq("stall_cnt", 32'(stall_cnt), 32'(mstall));
            if (exp_v) begin
                check_eq("rsp_p", 32'(rsp_p), 32'(q_p[0]));
                check_eq("rsp_id", 32'(rsp_id), 32'(q_id[0]));
            end
        end
    endtask

    task automatic advance();
        @(posedge ap_clk);
        last_xfer = 1'b0;
        if (ap_rst) begin
            q_p.delete();
            q_id.delete();
            q_out.delete();
            mptr   = 0;
            mstall = 0;
        end else begin
            if (exp_v && !rsp_ready && mstall < 65535) mstall++;
            if (exp_v && rsp_ready) begin
                void'(q_p.pop_front());
                void'(q_id.pop_front());
                void'(q_out.pop_front());
            end
            if (q_p.size() > 0 && !q_out[0]) q_out[0] = 1'b1;
            if (exp_rdy != '0) begin
                int pa;
                int pb;
                pa = int'(a_arr[exp_g]);
                pb = int'($signed(b_arr[exp_g]));
                q_p.push_back((pa * pb) & 32'h1FFF);
                q_id.push_back(exp_g);
                q_out.push_back(1'b0);
                mptr      = (exp_g + 1) % N;
                last_xfer = 1'b1;
                last_g    = exp_g;
            end
        end
        #1;
    endtask

    task automatic step();
        sample_check();
        advance();
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
    endtask

    task automatic refresh_accepted();
        if (last_xfer) begin
            a_arr[last_g] = 6'($urandom);
            b_arr[last_g] = 8'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        do_reset();

        // Single product with extreme operands.
        rsp_ready = 1'b1;
        a_arr[0]  = 6'd63;
        b_arr[0]  = 8'h80;
        req_valid = 4'b0001;
        sample_check();
        check_eq("single_ready", 32'(req_ready), 32'h1);
        advance();
        req_valid = '0;
        sample_check();
        check_eq("single_lat_v0", 32'(rsp_valid), 32'h0);
        advance();
        sample_check();
        check_eq("single_v", 32'(rsp_valid), 32'h1);
        check_eq("single_p", 32'(rsp_p), 32'h0080);
        check_eq("single_id", 32'(rsp_id), 32'h0);
        advance();

        // Sign extension on requester 2, then a zero product.
        a_arr[2]  = 6'd5;
        b_arr[2]  = 8'hFD;
        req_valid = 4'b0100;
        step();
        a_arr[2]  = 6'd0;
        b_arr[2]  = 8'd127;
        step();
        req_valid = '0;
        sample_check();
        check_eq("sext_p", 32'(rsp_p), 32'h1FF1);
        check_eq("sext_id", 32'(rsp_id), 32'h2);
        advance();
        sample_check();
        check_eq("zero_p", 32'(rsp_p), 32'h0);
        advance();
        step();

        // Full contention from ptr=0.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            sample_check();
            check_eq("cont_grant", 32'(req_ready), 32'(1 << (i % 4)));
            if (i >= 2) check_eq("cont_id", 32'(rsp_id), 32'((i - 2) % 4));
            advance();
            refresh_accepted();
        end
        req_valid = '0;
        step();
        step();

        // Wrap and skip: last grant 3, then only 1 and 3 compete.
        do_reset();
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            sample_check();
            check_eq("wrap_grant", 32'(req_ready), (i == 1) ? 32'h8 : 32'h2);
            advance();
            refresh_accepted();
        end
        req_valid = '0;
        step();
        step();

        // Back-pressure: fill both stages, then hold rsp_ready low.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        a_arr[0]  = 6'd17;
        b_arr[0]  = 8'h9C;
        step();
        refresh_accepted();
        step();
        for (int i = 0; i < 5; i++) begin
            sample_check();
            check_eq("bp_ready", 32'(req_ready), 32'h0);
            check_eq("bp_valid", 32'(rsp_valid), 32'h1);
            advance();
        end
        rsp_ready = 1'b1;
        sample_check();
        check_eq("bp_stall5", 32'(stall_cnt), 32'd5);
        advance();
        for (int i = 0; i < 5; i++) begin
            if (last_xfer) req_valid = '0;
            step();
        end
        sample_check();
        check_eq("bp_drained", 32'(busy), 32'h0);
        advance();

        // Reset with both stages full.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        refresh_accepted();
        step();
        req_valid = 4'hF;
        ap_rst    = 1'b1;
        step();
        ap_rst = 1'b0;
        sample_check();
        check_eq("rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_stall", 32'(stall_cnt), 32'h0);
        check_eq("rst_grant0", 32'(req_ready), 32'h1);
        advance();

        // Randomized traffic; requesters hold until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || (last_xfer && last_g == i)) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    a_arr[i]     = 6'($urandom);
                    b_arr[i]     = 8'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        sample_check();
        check_eq("final_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_cordiccart2pol_mul_arbiter
`default_nettype wire

// File: doc/cordiccart2pol_mul_arbiter.md
Name: cordiccart2pol_mul_arbiter

Overview:
Shares a single 6-bit unsigned × 8-bit signed → 13-bit multiplier among NUM_REQ requesters inside the cordiccart2pol datapath, e.g. gain compensation and the magnitude/angle scaling paths.
- Round-robin arbitration with per-requester valid/ready handshakes.
- Two-stage stallable pipeline: operand register, then product register.
- Tagged result stream and a saturating back-pressure counter.
- Sits between the CORDIC iteration control and the scaling stage; replaces per-requester multiplier instances.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_W, 6, operand A width, unsigned
B_W, 8, operand B width, signed two's complement
P_W, 13, product width; low P_W bits of the full (A_W+B_W)-bit signed product
ID_W, 2, tag width, equal to clog2(NUM_REQ)
CNT_W, 16, stall counter width

Ports:
ap_clk  in  1  clock; all logic is rising-edge
ap_rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
req_a  in  NUM_REQ*A_W  packed A operands; requester i uses slice [i*A_W +: A_W]
req_b  in  NUM_REQ*B_W  packed B operands; same slicing as req_a
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accept
rsp_p  out  P_W  product
rsp_id  out  ID_W  index of the requester that issued the product
busy  out  1  high while either pipeline stage holds data
stall_cnt  out  CNT_W  count of back-pressure cycles, saturating

Behaviour:
Reset:
- Applies when ap_rst is high at a rising edge of ap_clk.
- Clears S1/S2 valid bits, rsp_p, rsp_id, stall_cnt, and the round-robin pointer (ptr=0).
- Any in-flight data is discarded.
- While ap_rst is high, req_ready=0 and rsp_valid=0.

Pipeline:
- adv2 = !s2_v || rsp_ready.
- adv1 = !s1_v || adv2.
- S2 loads from S1 when adv2: s2_v<=s1_v, rsp_p<=trunc(prod(s1_a,s1_b)), rsp_id<=s1_id.
- S1 loads the granted request when adv1: s1_v<=any_grant.

Arbitration:
- Search req_valid starting at index ptr, ascending, wrapping from NUM_REQ-1 to 0.
- The first valid index found is granted.
- req_ready[g]=adv1 && grant[g]; req_ready may depend combinationally on req_valid and rsp_ready.
- A transfer is req_valid[g] && req_ready[g].
- On a transfer, ptr<=(g+1) mod NUM_REQ. Otherwise ptr holds.

Arithmetic:
- prod = signed({1'b0,a}) × signed(b), 14 bits.
- rsp_p = prod[P_W-1:0], two's-complement wrap, no saturation.
- The multiply is combinational between S1 and S2.

Latency and throughput:
- A transfer at edge k gives rsp_valid=1 after edge k+1, i.e. two cycles after accept when there is no stall.
- Throughput is one result per cycle when rsp_ready=1.

Handshake rules:
- A requester holds req_valid, req_a and req_b stable until it is accepted.
- While rsp_valid=1 && rsp_ready=0, rsp_p and rsp_id hold stable.
- No result is dropped or duplicated.

Stalls and counters:
- Full stall (s1_v && s2_v && !rsp_ready) forces all req_ready to 0.
- stall_cnt increments each cycle that rsp_valid && !rsp_ready; it holds at all-ones.
- busy = s1_v || s2_v.

Decomposition:
- Shared package cordiccart2pol_pkg holds: A_W, B_W, P_W and the derived full-product width; function clog2; typedef mul_req_t {a,b,id}.
- Sub-module cordiccart2pol_rr_pick: combinational rotate-priority picker. Inputs are req vector and ptr; outputs are one-hot grant and encoded index.
- Pipeline, pointer and counter logic stay in the top module.

Test Plan:
- Single product: req0 only, a=63, b=-128, rsp_ready=1, transfer at edge k → rsp_valid after edge k+1, rsp_p=13'h0080 (truncation of -8064), rsp_id=0.
- Signed sign extension: req2 only, a=5, b=-3 → rsp_p=13'h1FF1, rsp_id=2. Then a=0, b=127 → rsp_p=0.
- Full contention: all 4 req_valid held high, rsp_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles, one req_ready per cycle, rsp_id follows the same order.
- Wrap and skip: only req1 and req3 valid, last grant was 3 → next grant 1, then 3, then 1; ptr wraps from 3 to 0 without stalling.
- Back-pressure: pipeline full, rsp_ready=0 for 5 cycles → req_ready=0 throughout, rsp_p/rsp_id stable, stall_cnt=5. After release, both queued results emerge in order with no loss.
- Reset mid-flight: both stages full, ap_rst=1 for one cycle → next cycle rsp_valid=0, busy=0, stall_cnt=0, ptr=0. Requester 0 wins the first post-reset contention.
